qpu_event_timing_ctrl: RTL and testbench
========================================

Name: qpu_event_timing_ctrl

Overview:
- Receiving end of the QPU trigger interface.
- Owns the time base: drives the timestamp counter back to the core and honours the core's clock-enable.
- Accepts timestamped event words on EVENT_NUM independent channels and buffers each channel in a small FIFO.
- Issues each buffered codeword to the analog/AWG side on the exact cycle its timestamp matches the counter.

Parameters:
- EVENT_NUM, 4, number of event channels (matches core's event count).
- TIME_WIDTH, 32, width of the time counter and of each timestamp.
- CW_WIDTH, 16, width of the codeword per event.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- trigger_i_clk_ena  in  1  time counter enable from core.
- trigger_o_clk  out  TIME_WIDTH  current time counter value to core.
- trigger_i_data  in  EVENT_NUM*(TIME_WIDTH+CW_WIDTH)  per channel i, slice i = {timestamp[TIME_WIDTH-1:0], codeword[CW_WIDTH-1:0]}.
- trigger_i_valid  in  EVENT_NUM  per-channel write strobe; there is no ready signal.
- awg_o_codeword  out  EVENT_NUM*CW_WIDTH  issued codeword per channel.
- awg_o_valid  out  EVENT_NUM  one-cycle issue pulse per channel.
- sts_o_pending  out  EVENT_NUM  channel FIFO non-empty.
- sts_o_overflow  out  EVENT_NUM  sticky: write to a full FIFO.
- sts_o_late  out  EVENT_NUM  sticky: head timestamp already in the past.
- sts_i_clr  in  1  clears the sticky flags and the counter.

Behaviour:
- Reset: counter=0, all FIFOs empty, awg_o_valid=0, awg_o_codeword=0, all sts_o_* = 0. Reset mid-operation discards all queued events; no pulse is issued in the reset cycle or the following cycle.
- Counter: increments by 1 each cycle trigger_i_clk_ena=1 and holds otherwise. Wraps modulo 2^TIME_WIDTH. sts_i_clr=1 loads 0 and has priority over increment. trigger_o_clk is the registered counter value.
- Write: trigger_i_valid[i]=1 with FIFO i not full pushes the slice. The entry is visible at the head no earlier than the next cycle.
- Overflow: a write to a full FIFO is dropped, sets sts_o_overflow[i], and leaves contents unchanged.
- Compare: each cycle with trigger_i_clk_ena=1 and FIFO i non-empty, d = head.ts - trigger_o_clk is computed as a TIME_WIDTH-bit subtraction.
  - d==0: match.
  - d MSB=1: late.
  - otherwise: wait.
- Counter held: with trigger_i_clk_ena=0 there is no compare and no issue; entries wait.
- Issue on match: pop the head; next cycle awg_o_valid[i]=1 and awg_o_codeword[i]=head.cw. Latency is 1 cycle from the match cycle.
- Issue on late: pop, issue as for a match, and set sts_o_late[i] (default build).
- Rate limit: at most one pop per channel per cycle. Back-to-back equal timestamps: the second entry is late by 1 and is issued in the following cycle with late set.
- Simultaneous push and pop on a full FIFO: the pop frees an entry and the push is accepted, with no overflow.
- Channels are fully independent; simultaneous issues on all channels are allowed.
- awg_o_codeword[i] holds its last issued value when valid=0.
- sts_i_clr clears the overflow and late flags. If a flag-setting event occurs in the same cycle, the set wins.
- FIFO pointers carry an extra wrap bit for the full/empty distinction.
- sts_o_pending[i] = FIFO i non-empty (registered state).

Optional Feature:
- Macro: QPU_EVENT_LATE_DROP_EN.
- Defined: late entries are popped and discarded. No awg_o_valid pulse is produced; sts_o_late[i] is still set.
- Undefined: late entries are issued one cycle after detection, as described in Behaviour.

Test Plan:
- Basic issue: reset, ena=1, write ch0 {ts=20, cw=0xABCD} at time 5 → awg_o_valid[0]=1 with cw=0xABCD in the cycle after trigger_o_clk==20; all other channels stay silent.
- Overflow: ena=0, write 5 events to ch1 (FIFO_DEPTH=4) → sts_o_overflow[1]=1 and pending[1]=1. After ena=1 exactly 4 issues occur, in write order.
- Late event: counter at 100, write ch2 {ts=50, cw=0x1} → next-cycle issue of 0x1 with sts_o_late[2]=1. With QPU_EVENT_LATE_DROP_EN there is no issue, late=1, and pending returns to 0.
- Hold and wrap: TIME_WIDTH=8, counter 250, ts=3 written, ena toggles 0 for 10 cycles mid-way → issue occurs only when the counter reaches 3 after the wrap, with late=0.
- Equal timestamps: two ch3 entries with ts=40 → issues at counter 40+1 and 41+1, the second with late set. Concurrent ch0 ts=40 also issues at 41.
- Reset and clear: queue 3 events, assert rst for 1 cycle → no issues, pending=0, counter=0. Then set flags and pulse sts_i_clr → flags=0 and counter=0.

Source files
------------

// File: rtl/qpu_event_timing_ctrl.sv
// QPU trigger receiver: owns the time base, buffers timestamped events per channel
// and issues each codeword when its timestamp matches. Option: QPU_EVENT_LATE_DROP_EN.

module qpu_event_timing_ctrl_chan #(
   parameter int TIME_WIDTH = 32,
   parameter int CW_WIDTH   = 16,
   parameter int FIFO_DEPTH = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  clr,
   input  logic [TIME_WIDTH-1:0] cnt,
   input  logic                  wr_valid,
   input  logic [TIME_WIDTH+CW_WIDTH-1:0] wr_data,
   output logic                  issue_valid,
   output logic [CW_WIDTH-1:0]   issue_cw,
   output logic                  pending,
   output logic                  overflow,
   output logic                  late
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = TIME_WIDTH + CW_WIDTH;

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic                  empty, full;
   logic [EW-1:0]         head;
   logic [TIME_WIDTH-1:0] delta;
   logic                  chk, hit, is_late, pop, push, ovf_set, issue;

   // Extra MSB on the pointers separates full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head    = mem[rd_ptr[AW-1:0]];
   assign delta   = head[EW-1:CW_WIDTH] - cnt;
   assign chk     = ena && !empty;
   assign hit     = chk && (delta == '0);
   assign is_late = chk && delta[TIME_WIDTH-1];
   assign pop     = hit || is_late;
   assign push    = wr_valid && (!full || pop);
   assign ovf_set = wr_valid && full && !pop;
`ifdef QPU_EVENT_LATE_DROP_EN
   assign issue   = hit;
`else
   assign issue   = pop;
`endif
   assign pending = !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         issue_valid <= 1'b0;
         issue_cw    <= '0;
         overflow    <= 1'b0;
         late        <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         issue_valid <= issue;
         if (issue) issue_cw <= head[CW_WIDTH-1:0];
         // A set in the same cycle as a clear wins.
         overflow <= ovf_set || (overflow && !clr);
         late     <= is_late || (late && !clr);
      end
   end
endmodule

module qpu_event_timing_ctrl #(
   parameter int EVENT_NUM  = 4,
   parameter int TIME_WIDTH = 32,
   parameter int CW_WIDTH   = 16,
   parameter int FIFO_DEPTH = 4
)(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   trigger_i_clk_ena,
   output logic [TIME_WIDTH-1:0]                  trigger_o_clk,
   input  logic [EVENT_NUM*(TIME_WIDTH+CW_WIDTH)-1:0] trigger_i_data,
   input  logic [EVENT_NUM-1:0]                   trigger_i_valid,
   output logic [EVENT_NUM*CW_WIDTH-1:0]          awg_o_codeword,
   output logic [EVENT_NUM-1:0]                   awg_o_valid,
   output logic [EVENT_NUM-1:0]                   sts_o_pending,
   output logic [EVENT_NUM-1:0]                   sts_o_overflow,
   output logic [EVENT_NUM-1:0]                   sts_o_late,
   input  logic                                   sts_i_clr
);
   localparam int EW = TIME_WIDTH + CW_WIDTH;

   logic [TIME_WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || sts_i_clr)   cnt <= '0;
      else if (trigger_i_clk_ena) cnt <= cnt + 1'b1;
   end

   assign trigger_o_clk = cnt;

   for (genvar i = 0; i < EVENT_NUM; i++) begin : g_ch
      qpu_event_timing_ctrl_chan #(
         .TIME_WIDTH (TIME_WIDTH),
         .CW_WIDTH   (CW_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .ena         (trigger_i_clk_ena),
         .clr         (sts_i_clr),
         .cnt         (cnt),
         .wr_valid    (trigger_i_valid[i]),
         .wr_data     (trigger_i_data[i*EW +: EW]),
         .issue_valid (awg_o_valid[i]),
         .issue_cw    (awg_o_codeword[i*CW_WIDTH +: CW_WIDTH]),
         .pending     (sts_o_pending[i]),
         .overflow    (sts_o_overflow[i]),
         .late        (sts_o_late[i])
      );
   end
endmodule

// File: tb/tb_qpu_event_timing_ctrl.sv
// Bench for qpu_event_timing_ctrl (8-bit time base) with a queue-based reference model.
module tb_qpu_event_timing_ctrl;
   localparam int N = 4, TW = 8, CW = 16, D = 4, EW = TW + CW;

   logic clk = 1'b0, rst, ena, clr;
   logic [TW-1:0]   o_clk;
   logic [N*EW-1:0] i_data;
   logic [N-1:0]    i_valid, awg_valid, pend, ovf, late;
   logic [N*CW-1:0] awg_cw;

   int total = 0, bad = 0;

   logic [EW-1:0] mq [N][$];
   logic [TW-1:0] m_cnt = '0;
   logic [N-1:0]  m_valid = '0, m_ovf = '0, m_late = '0;
   logic [N*CW-1:0] m_cw = '0;

   qpu_event_timing_ctrl #(.EVENT_NUM(N), .TIME_WIDTH(TW), .CW_WIDTH(CW), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .trigger_i_clk_ena(ena), .trigger_o_clk(o_clk),
      .trigger_i_data(i_data), .trigger_i_valid(i_valid), .awg_o_codeword(awg_cw),
      .awg_o_valid(awg_valid), .sts_o_pending(pend), .sts_o_overflow(ovf),
      .sts_o_late(late), .sts_i_clr(clr));

   always #5 clk = ~clk;

   // Reference: event queues, signed distance by modular arithmetic, issue one cycle later.
   task automatic model_step();
      logic [EW-1:0] e;
      logic [TW-1:0] d;
      if (rst) begin
         for (int c = 0; c < N; c++) mq[c].delete();
         m_cnt = '0; m_valid = '0; m_cw = '0; m_ovf = '0; m_late = '0;
         return;
      end
      if (clr) begin m_ovf = '0; m_late = '0; end
      for (int c = 0; c < N; c++) begin
         m_valid[c] = 1'b0;
         if (ena && mq[c].size() > 0) begin
            e = mq[c][0];
            d = e[EW-1:CW] - m_cnt;
            if (d == 0 || d >= 8'd128) begin
               void'(mq[c].pop_front());
               if (d != 0) m_late[c] = 1'b1;
`ifdef QPU_EVENT_LATE_DROP_EN
               if (d == 0) begin m_valid[c] = 1'b1; m_cw[c*CW +: CW] = e[CW-1:0]; end
`else
               m_valid[c] = 1'b1; m_cw[c*CW +: CW] = e[CW-1:0];
`endif
            end
         end
         if (i_valid[c]) begin
            if (mq[c].size() < D) mq[c].push_back(i_data[c*EW +: EW]);
            else m_ovf[c] = 1'b1;
         end
      end
      if (clr) m_cnt = '0;
      else if (ena) m_cnt = m_cnt + 8'd1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic wr_set(input int ch, input logic [TW-1:0] ts, input logic [CW-1:0] cw);
      i_valid[ch] = 1'b1;
      i_data[ch*EW +: EW] = {ts, cw};
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; i_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b1; i_valid = '1; i_data = '1;
      tick();
      rst = 1'b0; i_valid = '0;
      total++; if (o_clk !== 8'd0)  begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_clk); end
      total++; if (awg_valid !== 4'd0) begin bad++; $display("FAIL reset_valid got=%b exp=0", awg_valid); end
      total++; if (awg_cw !== '0)   begin bad++; $display("FAIL reset_cw got=%h exp=0", awg_cw); end
      total++; if (pend !== 4'd0)   begin bad++; $display("FAIL reset_pend got=%b exp=0", pend); end
      total++; if ({ovf, late} !== 8'd0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {ovf, late}); end
   endtask

   task automatic test_basic();
      bit seen = 0;
      do_reset(); ena = 1'b1;
      for (int k = 0; k < 20 && o_clk != 8'd5; k++) tick();
      wr_set(0, 8'd20, 16'hABCD); tick(); i_valid = '0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (awg_valid != 0) begin seen = 1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL basic_timeout got=none exp=issue"); end
      total++; if (awg_valid !== 4'b0001) begin bad++; $display("FAIL basic_valid got=%b exp=0001", awg_valid); end
      total++; if (awg_cw[15:0] !== 16'hABCD) begin bad++; $display("FAIL basic_cw got=%h exp=abcd", awg_cw[15:0]); end
      total++; if (o_clk !== 8'd21) begin bad++; $display("FAIL basic_time got=%0d exp=21", o_clk); end
      total++; if (late !== 4'd0 || pend !== 4'd0) begin bad++; $display("FAIL basic_sts got=%b/%b exp=0/0", late, pend); end
   endtask

   task automatic test_overflow();
      logic [CW-1:0] got [$];
      bit other = 0;
      do_reset(); ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wr_set(1, 8'(10 + k), 16'(16'h100 + k)); tick();
      end
      i_valid = '0;
      total++; if (ovf !== 4'b0010) begin bad++; $display("FAIL ovf_flag got=%b exp=0010", ovf); end
      total++; if (pend !== 4'b0010) begin bad++; $display("FAIL ovf_pend got=%b exp=0010", pend); end
      ena = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (awg_valid[1]) got.push_back(awg_cw[31:16]);
         if (awg_valid[0] || awg_valid[3:2] != 0) other = 1;
      end
      total++; if (got.size() != 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", got.size()); end
      for (int k = 0; k < 4 && k < got.size(); k++) begin
         total++; if (got[k] !== 16'(16'h100 + k)) begin bad++; $display("FAIL ovf_order[%0d] got=%h exp=%h", k, got[k], 16'h100 + k); end
      end
      total++; if (other) begin bad++; $display("FAIL ovf_other got=issue exp=silent"); end
   endtask

   task automatic test_late();
      do_reset(); ena = 1'b1;
      repeat (100) tick();
      total++; if (o_clk !== 8'd100) begin bad++; $display("FAIL late_cnt got=%0d exp=100", o_clk); end
      wr_set(2, 8'd50, 16'h0001); tick(); i_valid = '0;
      tick();
`ifdef QPU_EVENT_LATE_DROP_EN
      total++; if (awg_valid !== 4'd0) begin bad++; $display("FAIL late_valid got=%b exp=0000", awg_valid); end
`else
      total++; if (awg_valid !== 4'b0100) begin bad++; $display("FAIL late_valid got=%b exp=0100", awg_valid); end
      total++; if (awg_cw[47:32] !== 16'h0001) begin bad++; $display("FAIL late_cw got=%h exp=0001", awg_cw[47:32]); end
`endif
      total++; if (late !== 4'b0100) begin bad++; $display("FAIL late_flag got=%b exp=0100", late); end
      total++; if (pend !== 4'd0) begin bad++; $display("FAIL late_pend got=%b exp=0", pend); end
   endtask

   task automatic test_wrap();
      bit early = 0, seen = 0;
      do_reset(); ena = 1'b1;
      for (int k = 0; k < 260 && o_clk != 8'd250; k++) tick();
      wr_set(0, 8'd3, 16'h0033); tick(); i_valid = '0;
      for (int k = 0; k < 10 && o_clk != 8'd253; k++) begin tick(); if (awg_valid != 0) early = 1; end
      ena = 1'b0;
      repeat (10) begin tick(); if (awg_valid != 0) early = 1; end
      total++; if (o_clk !== 8'd253) begin bad++; $display("FAIL wrap_hold got=%0d exp=253", o_clk); end
      ena = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (awg_valid != 0) begin seen = 1; break; end
      end
      total++; if (early || !seen) begin bad++; $display("FAIL wrap_issue got=early%0d/seen%0d exp=0/1", early, seen); end
      total++; if (o_clk !== 8'd4 || awg_cw[15:0] !== 16'h0033) begin bad++; $display("FAIL wrap_time got=%0d/%h exp=4/0033", o_clk, awg_cw[15:0]); end
      total++; if (late !== 4'd0) begin bad++; $display("FAIL wrap_late got=%b exp=0", late); end
   endtask

   task automatic test_equal_ts();
      int t3a = -1, t3b = -1, t0 = -1;
      logic [CW-1:0] c3a = '0, c3b = '0, c0 = '0;
      logic l3a = 1'b0, l3b = 1'b0;
      do_reset(); ena = 1'b1;
      for (int k = 0; k < 20 && o_clk != 8'd5; k++) tick();
      wr_set(3, 8'd40, 16'hA0A0); tick(); i_valid = '0;
      wr_set(3, 8'd40, 16'hB0B0); wr_set(0, 8'd40, 16'hC0C0); tick(); i_valid = '0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (awg_valid[3]) begin
            if (t3a < 0) begin t3a = int'(o_clk); c3a = awg_cw[63:48]; l3a = late[3]; end
            else if (t3b < 0) begin t3b = int'(o_clk); c3b = awg_cw[63:48]; l3b = late[3]; end
         end
         if (awg_valid[0] && t0 < 0) begin t0 = int'(o_clk); c0 = awg_cw[15:0]; end
      end
      total++; if (t3a != 41 || c3a !== 16'hA0A0 || l3a !== 1'b0) begin bad++; $display("FAIL eq_first got=%0d/%h/%b exp=41/a0a0/0", t3a, c3a, l3a); end
      total++; if (t0 != 41 || c0 !== 16'hC0C0) begin bad++; $display("FAIL eq_ch0 got=%0d/%h exp=41/c0c0", t0, c0); end
`ifdef QPU_EVENT_LATE_DROP_EN
      total++; if (t3b != -1 || late[3] !== 1'b1) begin bad++; $display("FAIL eq_second got=%0d/%b exp=-1/1", t3b, late[3]); end
`else
      total++; if (t3b != 42 || c3b !== 16'hB0B0 || l3b !== 1'b1) begin bad++; $display("FAIL eq_second got=%0d/%h/%b exp=42/b0b0/1", t3b, c3b, l3b); end
`endif
   endtask

   task automatic test_reset_clear();
      do_reset(); ena = 1'b1;
      wr_set(0, 8'd100, 16'h1); wr_set(1, 8'd100, 16'h2); wr_set(2, 8'd100, 16'h3); tick(); i_valid = '0;
      tick();
      rst = 1'b1; tick();
      total++; if (awg_valid !== 4'd0 || pend !== 4'd0 || o_clk !== 8'd0) begin bad++; $display("FAIL rst_mid got=%b/%b/%0d exp=0/0/0", awg_valid, pend, o_clk); end
      rst = 1'b0; tick();
      total++; if (awg_valid !== 4'd0 || o_clk !== 8'd1) begin bad++; $display("FAIL rst_after got=%b/%0d exp=0/1", awg_valid, o_clk); end
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin wr_set(1, o_clk + 8'd50, 16'(k)); tick(); end
      wr_set(2, o_clk + 8'd200, 16'h7); i_valid[1] = 1'b0; tick(); i_valid = '0;
      ena = 1'b1; repeat (3) tick();
      total++; if (ovf[1] !== 1'b1 || late[2] !== 1'b1) begin bad++; $display("FAIL clr_pre got=%b/%b exp=1/1", ovf[1], late[2]); end
      clr = 1'b1; tick(); clr = 1'b0;
      total++; if (ovf !== 4'd0 || late !== 4'd0 || o_clk !== 8'd0) begin bad++; $display("FAIL clr_post got=%b/%b/%0d exp=0/0/0", ovf, late, o_clk); end
   endtask

   task automatic test_random();
      logic [N-1:0] mp;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         ena = ($urandom % 4) != 0;
         clr = ($urandom % 50) == 0;
         rst = ($urandom % 250) == 0;
         i_valid = '0;
         for (int c = 0; c < N; c++)
            if ($urandom % 3 == 0) wr_set(c, m_cnt + 8'($urandom_range(0, 40)) - 8'd6, 16'($urandom));
         tick();
         for (int c = 0; c < N; c++) mp[c] = mq[c].size() != 0;
         total++; if (o_clk !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", k, o_clk, m_cnt); end
         total++; if (awg_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", k, awg_valid, m_valid); end
         total++; if (awg_cw !== m_cw) begin bad++; $display("FAIL rnd_cw[%0d] got=%h exp=%h", k, awg_cw, m_cw); end
         total++; if (pend !== mp) begin bad++; $display("FAIL rnd_pend[%0d] got=%b exp=%b", k, pend, mp); end
         total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", k, ovf, m_ovf); end
         total++; if (late !== m_late) begin bad++; $display("FAIL rnd_late[%0d] got=%b exp=%b", k, late, m_late); end
      end
      rst = 1'b0; clr = 1'b0; i_valid = '0;
   endtask

   initial begin
      rst = 1'b0; ena = 1'b0; clr = 1'b0; i_valid = '0; i_data = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_overflow();
      test_late();
      test_wrap();
      test_equal_ts();
      test_reset_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
